multibyte_instruction_register: RTL and testbench
=================================================

Name: multibyte_instruction_register

Overview:
Parametrised instruction register for the 8-bit computer family.
- Captures one opcode word plus a variable number of operand words (0..MAX_OPERANDS) from the shared tristate bus over successive II strobes.
- Exposes opcode, immediate field and the assembled operand to the control unit.
- Drives the immediate field or any operand word back onto the bus.
- Replaces the single-word IR so multi-word instructions (e.g. 16-bit addresses) need no extra registers.

Parameters:
DATA_WIDTH, 8, bus and register word width.
OPCODE_WIDTH, 4, upper bits of the first word treated as opcode; must be 1..DATA_WIDTH-1.
MAX_OPERANDS, 2, maximum operand words per instruction; must be >= 1.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  synchronous reset, active-low (rst==0 at posedge resets).
bus  inout  DATA_WIDTH  shared system bus.
II  in  1  load strobe: capture bus into next instruction word.
IO  in  1  drive zero-extended immediate field onto bus.
AO  in  1  drive operand word selected by ao_sel onto bus.
ao_sel  in  max(1,$clog2(MAX_OPERANDS))  operand word index for AO.
op_len  in  $clog2(MAX_OPERANDS+1)  operand count for opcode currently on bus; combinationally decoded by control; sampled only on opcode capture.
clr  in  1  abort/retire instruction, return to opcode fetch.
opcode  out  OPCODE_WIDTH  bits [DATA_WIDTH-1 -: OPCODE_WIDTH] of first word.
imm  out  DATA_WIDTH-OPCODE_WIDTH  low bits of first word.
operand  out  MAX_OPERANDS*DATA_WIDTH  operand words, word 0 in least-significant position.
ready  out  1  instruction fully captured.
word_idx  out  $clog2(MAX_OPERANDS+1)  operand words captured so far.
err  out  1  sticky error flag.

Behaviour:
- Reset (rst==0): state FETCH_OP, opcode/imm/operand=0, len=0, word_idx=0, ready=0, err=0. Reset dominates all other inputs, including mid-fetch.
- Priority each cycle: rst > clr > II. clr: state FETCH_OP, word_idx=0, ready=0; opcode/imm/operand retained; err unchanged.
- FETCH_OP, II=1:
  - latch bus into opcode/imm; latch len=min(op_len, MAX_OPERANDS).
  - If op_len>MAX_OPERANDS, set err.
  - If len==0, go to READY (ready=1 next cycle); else go to FETCH_ARG, word_idx=0.
- FETCH_ARG, II=1:
  - bus -> operand word word_idx; word_idx++.
  - When the incremented word_idx==len, go to READY.
  - One word per strobe; no wrap.
- READY: ready=1. II=1 is a new opcode capture, treated exactly as FETCH_OP; back-to-back instructions need no clr. ready falls the cycle after an opcode capture with len>0.
- II absent: all state holds; no timeout.
- Outputs are registered; opcode/operand are visible the cycle after the capturing edge.
- Bus drive (combinational):
  - AO=1 drives operand[ao_sel].
  - Else IO=1 drives {zeros, imm}.
  - Else high-Z.
  - AO has priority over IO.
  - ao_sel>=MAX_OPERANDS drives all zeros.
- II asserted with IO or AO in the same cycle: capture suppressed, state held, err set.
- err is cleared only by reset.

Optional Feature:
IR_OPERAND_CLEAR_EN:
- Defined: every opcode capture also zeroes all operand words in the same edge, so unused words of short instructions read 0.
- Undefined: operand words not written by the current instruction keep stale values from earlier instructions.

Decomposition:
Shared package ir_pkg:
- state enum {FETCH_OP, FETCH_ARG, READY}.
- Localparam helpers for index widths (IDX_W, LEN_W).
- Default width constants shared with control unit decode.
Sub-module ir_bus_driver: combinational AO/IO priority mux plus tristate enable. Keeps the FSM module free of inout logic.

Test Plan:
1. Opcode 0x35 with op_len=0, II one cycle -> opcode=3, imm=5, ready=1 next cycle, word_idx=0. IO=1 then -> bus=0x05.
2. Opcode 0xA0 op_len=2, then II with 0x34, then II with 0x12 -> operand=0x1234, ready only after third strobe. AO, ao_sel=1 -> bus=0x12.
3. op_len=3 with MAX_OPERANDS=2 -> err=1, len clamped to 2, ready after two operand words.
4. rst=0 after the first operand word -> all outputs 0, FETCH_OP. Next II captures as opcode.
5. In READY, II with new opcode 0x70 op_len=1 -> ready=0, word_idx=0, operand word 0 becomes 0 only with IR_OPERAND_CLEAR_EN.
6. II with AO=1 -> no capture, err=1. IO and AO together -> AO value on bus.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared types and width helpers for the multi-word instruction register.
// Used by the IR, its bus driver and the control unit decode.
package ir_pkg;

    typedef enum logic [1:0] {
        FETCH_OP,
        FETCH_ARG,
        READY
    } ir_state_e;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_OPCODE_WIDTH = 4;
    localparam int DEF_MAX_OPERANDS = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int len_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int IDX_W = idx_w(DEF_MAX_OPERANDS);
    localparam int LEN_W = len_w(DEF_MAX_OPERANDS);

endpackage

// File: rtl/multibyte_instruction_register_if.sv
// Control-unit <-> instruction register strobe and status bundle.
// The shared data bus stays a plain inout on the IR itself.
interface multibyte_instruction_register_if
    import ir_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter int MAX_OPERANDS = DEF_MAX_OPERANDS
);
    localparam int IW = idx_w(MAX_OPERANDS);
    localparam int LW = len_w(MAX_OPERANDS);

    logic                               II;
    logic                               IO;
    logic                               AO;
    logic [IW-1:0]                      ao_sel;
    logic [LW-1:0]                      op_len;
    logic                               clr;
    logic [OPCODE_WIDTH-1:0]            opcode;
    logic [DATA_WIDTH-OPCODE_WIDTH-1:0] imm;
    logic [MAX_OPERANDS*DATA_WIDTH-1:0] operand;
    logic                               ready;
    logic [LW-1:0]                      word_idx;
    logic                               err;

    modport master (
        output II, IO, AO, ao_sel, op_len, clr,
        input  opcode, imm, operand, ready, word_idx, err
    );

    modport slave (
        input  II, IO, AO, ao_sel, op_len, clr,
        output opcode, imm, operand, ready, word_idx, err
    );

endinterface

// File: rtl/ir_bus_driver.sv
// Tristate bus driver for the IR: operand word (AO) beats immediate (IO).
// Out-of-range operand selects drive zero.
module ir_bus_driver
    import ir_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter int MAX_OPERANDS = DEF_MAX_OPERANDS
) (
    input  logic                               AO,
    input  logic                               IO,
    input  logic [idx_w(MAX_OPERANDS)-1:0]     ao_sel,
    input  logic [DATA_WIDTH-OPCODE_WIDTH-1:0] imm,
    input  logic [MAX_OPERANDS*DATA_WIDTH-1:0] operand,
    inout  wire  [DATA_WIDTH-1:0]              bus
);
    localparam int IW = idx_w(MAX_OPERANDS);

    logic [DATA_WIDTH-1:0] dout;
    logic                  oe;

    always_comb begin
        dout = '0;
        oe   = AO | IO;
        if (AO) begin
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                if (ao_sel == IW'(i)) begin
                    dout = operand[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end else if (IO) begin
            dout = DATA_WIDTH'(imm);
        end
    end

    assign bus = oe ? dout : 'z;

endmodule

// File: rtl/multibyte_instruction_register.sv
// Multi-word instruction register: opcode word plus 0..MAX_OPERANDS operands.
// Define IR_OPERAND_CLEAR_EN to zero all operand words on each opcode capture.
module multibyte_instruction_register
    import ir_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter int MAX_OPERANDS = DEF_MAX_OPERANDS
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [DATA_WIDTH-1:0] bus,
    multibyte_instruction_register_if.slave ctl
);
    localparam int LW    = len_w(MAX_OPERANDS);
    localparam int IMM_W = DATA_WIDTH - OPCODE_WIDTH;
    localparam int OPW   = MAX_OPERANDS * DATA_WIDTH;

    ir_state_e               state_q, state_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [IMM_W-1:0]        imm_q, imm_d;
    logic [OPW-1:0]          operand_q, operand_d;
    logic [LW-1:0]           len_q, len_d;
    logic [LW-1:0]           idx_q, idx_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   bus_in;
    logic [LW-1:0]           len_cap;
    logic [LW-1:0]           idx_inc;
    logic                    too_long;
    logic                    blocked;

    assign bus_in   = bus;
    assign too_long = ctl.op_len > LW'(MAX_OPERANDS);
    assign len_cap  = too_long ? LW'(MAX_OPERANDS) : ctl.op_len;
    assign idx_inc  = idx_q + LW'(1);
    // Capturing while we drive the bus would latch our own value.
    assign blocked  = ctl.II & (ctl.IO | ctl.AO);

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        imm_d     = imm_q;
        operand_d = operand_q;
        len_d     = len_q;
        idx_d     = idx_q;
        err_d     = err_q;
        if (ctl.clr) begin
            state_d = FETCH_OP;
            idx_d   = '0;
        end else if (blocked) begin
            err_d = 1'b1;
        end else if (ctl.II) begin
            unique case (state_q)
                FETCH_OP, READY: begin
                    opcode_d = bus_in[DATA_WIDTH-1 -: OPCODE_WIDTH];
                    imm_d    = bus_in[IMM_W-1:0];
                    len_d    = len_cap;
                    idx_d    = '0;
                    if (too_long) err_d = 1'b1;
`ifdef IR_OPERAND_CLEAR_EN
                    operand_d = '0;
`else
                    operand_d = operand_q;
`endif
                    state_d = (len_cap == '0) ? READY : FETCH_ARG;
                end
                FETCH_ARG: begin
                    for (int i = 0; i < MAX_OPERANDS; i++) begin
                        if (idx_q == LW'(i)) begin
                            operand_d[i*DATA_WIDTH +: DATA_WIDTH] = bus_in;
                        end
                    end
                    idx_d = idx_inc;
                    if (idx_inc == len_q) state_d = READY;
                end
                default: state_d = FETCH_OP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FETCH_OP;
            opcode_q  <= '0;
            imm_q     <= '0;
            operand_q <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            imm_q     <= imm_d;
            operand_q <= operand_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
        end
    end

    assign ctl.opcode   = opcode_q;
    assign ctl.imm      = imm_q;
    assign ctl.operand  = operand_q;
    assign ctl.ready    = (state_q == READY);
    assign ctl.word_idx = idx_q;
    assign ctl.err      = err_q;

    ir_bus_driver #(
        .DATA_WIDTH  (DATA_WIDTH),
        .OPCODE_WIDTH(OPCODE_WIDTH),
        .MAX_OPERANDS(MAX_OPERANDS)
    ) u_drv (
        .AO     (ctl.AO),
        .IO     (ctl.IO),
        .ao_sel (ctl.ao_sel),
        .imm    (imm_q),
        .operand(operand_q),
        .bus    (bus)
    );

endmodule

// File: tb/tb_multibyte_instruction_register.sv
// Scoreboard bench for multibyte_instruction_register.
// Model tracks instructions as (opcode, needed, received) counts.
module tb_multibyte_instruction_register;
    import ir_pkg::*;

    localparam int DW   = 8;
    localparam int OW   = 4;
    localparam int MAXO = 2;
    localparam int IW   = idx_w(MAXO);
    localparam int LW   = len_w(MAXO);

    logic          clk = 1'b0;
    logic          rst;
    wire  [DW-1:0] bus;
    logic          tb_oe;
    logic [DW-1:0] tb_bus;

    always #5 clk = ~clk;

    assign bus = tb_oe ? tb_bus : 'z;

    multibyte_instruction_register_if #(
        .DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .MAX_OPERANDS(MAXO)
    ) ctl_if ();

    multibyte_instruction_register #(
        .DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .MAX_OPERANDS(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .ctl(ctl_if)
    );

    typedef struct {
        bit              chk_bus;
        logic [DW-1:0]   bus_v;
        logic [OW-1:0]   opcode;
        logic [DW-OW-1:0] imm;
        logic [MAXO*DW-1:0] operand;
        bit              ready;
        logic [LW-1:0]   widx;
        bit              err;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: instruction-level view.
    bit            known = 0;
    bit            have_op;
    int            need;
    int            got;
    logic [DW-1:0] opw;
    logic [DW-1:0] ops[MAXO];
    bit            m_err;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    exp_t e;
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("opcode", 64'(ctl_if.opcode), 64'(e.opcode));
                check("imm", 64'(ctl_if.imm), 64'(e.imm));
                check("operand", 64'(ctl_if.operand), 64'(e.operand));
                check("ready", 64'(ctl_if.ready), 64'(e.ready));
                check("word_idx", 64'(ctl_if.word_idx), 64'(e.widx));
                check("err", 64'(ctl_if.err), 64'(e.err));
                if (e.chk_bus) check("bus", 64'(bus), 64'(e.bus_v));
            end
        end
    end

    function automatic bit m_ready();
        return have_op && (got == need);
    endfunction

    task automatic step(input bit r, input bit c, input bit ii,
                        input bit io, input bit ao,
                        input logic [IW-1:0] sel,
                        input logic [LW-1:0] ol,
                        input logic [DW-1:0] d);
        exp_t x;
        rst           = r;
        ctl_if.clr    = c;
        ctl_if.II     = ii;
        ctl_if.IO     = io;
        ctl_if.AO     = ao;
        ctl_if.ao_sel = sel;
        ctl_if.op_len = ol;
        tb_oe         = ii && !io && !ao;
        tb_bus        = d;
        if (known) begin
            x.chk_bus = io || ao;
            if (ao) x.bus_v = (int'(sel) < MAXO) ? ops[sel] : '0;
            else    x.bus_v = DW'(opw[DW-OW-1:0]);
            x.opcode = opw[DW-1 -: OW];
            x.imm    = opw[DW-OW-1:0];
            for (int i = 0; i < MAXO; i++) x.operand[i*DW +: DW] = ops[i];
            x.ready  = m_ready();
            x.widx   = LW'(got);
            x.err    = m_err;
            q.push_back(x);
        end
        @(posedge clk);
        if (!r) begin
            known = 1; have_op = 0; need = 0; got = 0;
            opw = '0; m_err = 0;
            for (int i = 0; i < MAXO; i++) ops[i] = '0;
        end else if (c) begin
            have_op = 0; got = 0;
        end else if (ii) begin
            if (io || ao) begin
                m_err = 1;
            end else if (!have_op || m_ready()) begin
                opw = d; have_op = 1; got = 0;
                need = (int'(ol) > MAXO) ? MAXO : int'(ol);
                if (int'(ol) > MAXO) m_err = 1;
`ifdef IR_OPERAND_CLEAR_EN
                for (int i = 0; i < MAXO; i++) ops[i] = '0;
`endif
            end else begin
                ops[got] = d;
                got++;
            end
        end
        #1;
    endtask

    initial begin
        rst = 0; tb_oe = 0; tb_bus = '0;
        ctl_if.clr = 0; ctl_if.II = 0; ctl_if.IO = 0; ctl_if.AO = 0;
        ctl_if.ao_sel = '0; ctl_if.op_len = '0;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 2, 8'hff);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // 1: single-word instruction then immediate readback
        step(1, 0, 1, 0, 0, 0, 0, 8'h35);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        // 2: two operand words, readback both
        step(1, 0, 1, 0, 0, 0, 2, 8'hA0);
        step(1, 0, 1, 0, 0, 0, 0, 8'h34);
        step(1, 0, 1, 0, 0, 0, 0, 8'h12);
        step(1, 0, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // 3: over-long op_len clamps and flags err
        step(1, 0, 1, 0, 0, 0, 3, 8'h9C);
        step(1, 0, 1, 0, 0, 0, 0, 8'h56);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 8'h78);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // 4: reset mid-fetch, next strobe is an opcode
        step(1, 0, 1, 0, 0, 0, 2, 8'h11);
        step(1, 0, 1, 0, 0, 0, 0, 8'hAB);
        step(0, 0, 1, 0, 0, 0, 0, 8'hCD);
        step(1, 0, 1, 0, 0, 0, 0, 8'h22);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // 5: back-to-back from READY
        step(1, 0, 1, 0, 0, 0, 2, 8'h40);
        step(1, 0, 1, 0, 0, 0, 0, 8'hEE);
        step(1, 0, 1, 0, 0, 0, 0, 8'hDD);
        step(1, 0, 1, 0, 0, 0, 1, 8'h70);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 8'h99);
        // 6: II with AO blocked; AO beats IO
        step(1, 0, 1, 0, 1, 1, 0, 8'h00);
        step(1, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0, 8'h00);
        // clr mid-fetch
        step(1, 0, 1, 0, 0, 0, 2, 8'h5A);
        step(1, 1, 1, 0, 0, 0, 0, 8'h33);
        step(1, 0, 1, 0, 0, 0, 1, 8'h61);
        step(1, 0, 1, 0, 0, 0, 0, 8'h62);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 49) != 0,
                 $urandom_range(0, 19) == 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 IW'($urandom_range(0, MAXO - 1)),
                 LW'($urandom_range(0, (1 << LW) - 1)),
                 DW'($urandom()));
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
